// File: rtl/ahb_lite_uart_tx_master_pkg.sv
// Shared AHB-Lite encodings, UART16550 register map and FSM state types
// for the UART transmit bus master and its helpers.
package ahb_lite_uart_pkg;

    localparam logic [1:0] HTRANS_IDLE     = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
    localparam logic [2:0] HSIZE_WORD      = 3'b010;
    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    // UART16550 register indices; byte address is base + 4*index
    localparam int UART_THR = 0;
    localparam int UART_DLL = 0;
    localparam int UART_DLM = 1;
    localparam int UART_IER = 1;
    localparam int UART_FCR = 2;
    localparam int UART_LCR = 3;
    localparam int UART_LSR = 5;

    // LSR bit: transmit holding register empty
    localparam int LSR_THRE = 5;

    typedef enum logic [2:0] {
        SEQ_CFG0,
        SEQ_CFG1,
        SEQ_CFG2,
        SEQ_CFG3,
        SEQ_CFG4,
        SEQ_POLL,
        SEQ_WRITE
    } seq_state_e;

    typedef enum logic [1:0] {
        B_IDLE,
        B_ADDR,
        B_DATA
    } bus_state_e;

    function automatic logic [31:0] reg_addr(input logic [31:0] base, input int idx);
        return base + (32'(idx) << 2);
    endfunction

endpackage

// File: rtl/ahb_lite_uart_tx_master_if.sv
// AHB-Lite single-master bus bundle between the UART TX master and the UART slave.
// Pure wiring, no latency.
// Backpressure is carried by HREADY from the slave.
interface ahb_lite_uart_tx_master_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_uart_tx_master_tx_byte_fifo.sv
// Synchronous byte FIFO decoupling the producer from AHB bus latency.
// Push visible at head one cycle later; head is combinational from storage.
// full_o refuses pushes; a push while full is dropped even if a pop happens that cycle.
module tx_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rptr_q];

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (!do_push && do_pop) count_q <= count_q - CW'(1);
        end
    end

    // storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end
endmodule

// File: rtl/ahb_lite_uart_tx_master.sv
// AHB-Lite master that configures a UART16550 and streams buffered bytes into THR.
// One transfer in flight, min 3 cycles each (idle/address/data); bytes buffered in a FIFO.
// in_ready drops only when the FIFO is full or during reset; HREADY stalls the bus FSM.
module ahb_lite_uart_tx_master
    import ahb_lite_uart_pkg::*;
#(
    parameter logic [31:0] UART_BASE  = 32'h1060_0000,
    parameter logic [15:0] DIVISOR    = 16'd27,
    parameter bit          INIT_EN    = 1'b1,
    parameter int          FIFO_DEPTH = 16,
    parameter int          TX_CHUNK   = 16
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    ahb_lite_uart_tx_master_if.master       ahb,
    output logic                            busy,
    output logic                            cfg_done,
    output logic                            err
);
    localparam int CHW = $clog2(TX_CHUNK + 1);

    bus_state_e  bus_q, bus_d;
    seq_state_e  seq_q, seq_d;
    logic [31:0] haddr_q, haddr_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        hwrite_q, hwrite_d;
    logic [CHW-1:0] chunk_q, chunk_d;
    logic        cfg_done_q, cfg_done_d;
    logic        err_q, err_d;

    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;

    function automatic logic [31:0] cfg_addr(input seq_state_e s);
        logic [31:0] a;
        case (s)
            SEQ_CFG1: a = reg_addr(UART_BASE, UART_DLL);
            SEQ_CFG2: a = reg_addr(UART_BASE, UART_DLM);
            SEQ_CFG4: a = reg_addr(UART_BASE, UART_FCR);
            default:  a = reg_addr(UART_BASE, UART_LCR);
        endcase
        return a;
    endfunction

    function automatic logic [7:0] cfg_data(input seq_state_e s);
        logic [7:0] d;
        case (s)
            SEQ_CFG0: d = 8'h83;           // DLAB=1, 8N1
            SEQ_CFG1: d = DIVISOR[7:0];
            SEQ_CFG2: d = DIVISOR[15:8];
            SEQ_CFG3: d = 8'h03;           // DLAB=0, 8N1
            default:  d = 8'h07;           // enable and clear both FIFOs
        endcase
        return d;
    endfunction

    assign in_ready  = HRESETn && !fifo_full;
    assign fifo_push = in_valid && in_ready;

    tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .push_i  (fifo_push),
        .din_i   (in_data),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign ahb.HTRANS    = (bus_q == B_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahb.HADDR     = haddr_q;
    assign ahb.HWRITE    = hwrite_q;
    assign ahb.HWDATA    = hwdata_q;
    assign ahb.HSIZE     = HSIZE_WORD;
    assign ahb.HBURST    = HBURST_SINGLE;
    assign ahb.HPROT     = HPROT_DATA_PRIV;
    assign ahb.HMASTLOCK = 1'b0;

    assign busy     = !fifo_empty || (bus_q != B_IDLE);
    assign cfg_done = cfg_done_q;
    assign err      = err_q;

    // bus FSM and sequencer next state; the sequencer only moves on transfer completion
    always_comb begin
        bus_d      = bus_q;
        seq_d      = seq_q;
        haddr_d    = haddr_q;
        hwdata_d   = hwdata_q;
        hwrite_d   = hwrite_q;
        chunk_d    = chunk_q;
        cfg_done_d = cfg_done_q;
        err_d      = err_q;
        fifo_pop   = 1'b0;

        if (!INIT_EN) cfg_done_d = 1'b1;

        case (bus_q)
            B_IDLE: begin
                case (seq_q)
                    SEQ_CFG0, SEQ_CFG1, SEQ_CFG2, SEQ_CFG3, SEQ_CFG4: begin
                        bus_d    = B_ADDR;
                        hwrite_d = 1'b1;
                        haddr_d  = cfg_addr(seq_q);
                        hwdata_d = {24'h0, cfg_data(seq_q)};
                    end
                    SEQ_POLL: begin
                        // poll only when there is something to send
                        if (!fifo_empty) begin
                            bus_d    = B_ADDR;
                            hwrite_d = 1'b0;
                            haddr_d  = reg_addr(UART_BASE, UART_LSR);
                            hwdata_d = '0;
                        end
                    end
                    SEQ_WRITE: begin
                        // byte leaves the FIFO as the address phase begins
                        if (!fifo_empty) begin
                            bus_d    = B_ADDR;
                            hwrite_d = 1'b1;
                            haddr_d  = reg_addr(UART_BASE, UART_THR);
                            hwdata_d = {24'h0, fifo_head};
                            fifo_pop = 1'b1;
                        end else begin
                            seq_d = SEQ_POLL;
                        end
                    end
                    default: ;
                endcase
            end
            B_ADDR: begin
                if (ahb.HREADY) bus_d = B_DATA;
            end
            B_DATA: begin
                if (ahb.HRESP) err_d = 1'b1;
                if (ahb.HREADY) begin
                    bus_d = B_IDLE;
                    case (seq_q)
                        SEQ_CFG0: seq_d = SEQ_CFG1;
                        SEQ_CFG1: seq_d = SEQ_CFG2;
                        SEQ_CFG2: seq_d = SEQ_CFG3;
                        SEQ_CFG3: seq_d = SEQ_CFG4;
                        SEQ_CFG4: begin
                            seq_d      = SEQ_POLL;
                            cfg_done_d = 1'b1;
                        end
                        SEQ_POLL: begin
                            if (ahb.HRDATA[LSR_THRE]) begin
                                chunk_d = CHW'(TX_CHUNK);
                                seq_d   = SEQ_WRITE;
                            end
                        end
                        SEQ_WRITE: begin
                            // errored writes still count; the byte is not retried
                            chunk_d = chunk_q - CHW'(1);
                            if (chunk_q == CHW'(1) || fifo_empty) seq_d = SEQ_POLL;
                        end
                        default: ;
                    endcase
                end
            end
            default: bus_d = B_IDLE;
        endcase
    end

    // state registers; reset abandons any transfer in flight
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            bus_q      <= B_IDLE;
            seq_q      <= INIT_EN ? SEQ_CFG0 : SEQ_POLL;
            haddr_q    <= '0;
            hwdata_q   <= '0;
            hwrite_q   <= 1'b0;
            chunk_q    <= '0;
            cfg_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            bus_q      <= bus_d;
            seq_q      <= seq_d;
            haddr_q    <= haddr_d;
            hwdata_q   <= hwdata_d;
            hwrite_q   <= hwrite_d;
            chunk_q    <= chunk_d;
            cfg_done_q <= cfg_done_d;
            err_q      <= err_d;
        end
    end
endmodule
